router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router. Sits between the input port and the register/FIFO datapath, and decodes the header address. It steps the register block through its header, payload, full-stall, parity and error-check phases by driving the register block's one-hot phase strobes. It also gates FIFO writes and signals `busy` back to the source.

## Interface
- `INVALID_ADDR`, default 2'b11: destination code that is never accepted.
- `clock` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; forces DECODE_ADDRESS.
- `pkt_valid` in 1: source asserts for header and payload bytes, drops on the parity byte.
- `data_in` in 2: header address bits [1:0] of the input byte.
- `fifo_full` in 1: full flag of the currently selected FIFO.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-port FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port read-timeout resets.
- `parity_done` in 1: from the register block.
- `low_pkt_valid` in 1: from the register block.
- `detect_add` out 1: high in DECODE_ADDRESS.
- `lfd_state` out 1: high in LOAD_FIRST_DATA.
- `ld_state` out 1: high in LOAD_DATA.
- `laf_state` out 1: high in LOAD_AFTER_FULL.
- `full_state` out 1: high in FIFO_FULL_STATE.
- `rst_int_reg` out 1: high in CHECK_PARITY_ERROR.
- `write_enb_reg` out 1: FIFO write enable.
- `busy` out 1: source must hold its byte while high.

## Operation
- Moore FSM with eight states, plus a 2-bit `addr_q` register.
- **DECODE_ADDRESS** (reset state):
  - Transitions only when `pkt_valid` is 1 and `data_in` ≠ INVALID_ADDR; otherwise it stays.
  - On transition, `addr_q` ← `data_in`.
  - If `fifo_empty[data_in]` is 1 → LOAD_FIRST_DATA, else → WAIT_TILL_EMPTY. This decision uses the live `data_in`, not `addr_q`.
- **WAIT_TILL_EMPTY**: → LOAD_FIRST_DATA when `fifo_empty[addr_q]`; otherwise stays.
- **LOAD_FIRST_DATA**: → LOAD_DATA unconditionally.
- **LOAD_DATA**, priority order:
  1. `fifo_full` → FIFO_FULL_STATE.
  2. `!pkt_valid` → LOAD_PARITY.
  3. Otherwise stay.
- **FIFO_FULL_STATE**: → LOAD_AFTER_FULL when `!fifo_full`; otherwise stays.
- **LOAD_AFTER_FULL**:
  - `parity_done` → DECODE_ADDRESS.
  - Else `low_pkt_valid` → LOAD_PARITY.
  - Else → LOAD_DATA.
- **LOAD_PARITY**: → CHECK_PARITY_ERROR unconditionally.
- **CHECK_PARITY_ERROR**: `fifo_full` → FIFO_FULL_STATE, else → DECODE_ADDRESS.
- **Soft reset**: `soft_reset[addr_q]` = 1 in any state other than DECODE_ADDRESS → DECODE_ADDRESS. It overrides every other transition and leaves `addr_q` unchanged. Soft resets of non-selected ports are ignored.
- **Reset priority**: `reset` beats `soft_reset`, which beats normal transitions.
- **Output decode**:
  - `write_enb_reg` = LOAD_FIRST_DATA | LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - `busy` = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- **Reset values**: `detect_add` = 1, `addr_q` = 0, every other output = 0.

## Timing
- All outputs are combinational decodes of registered state. They change one cycle after the qualifying input edge and never combinationally from inputs.
- **Header**: byte accepted at edge N; `lfd_state` = 1 in cycle N+1 and `ld_state` = 1 in cycle N+2, provided the FIFO was empty.
- **Parity byte**: `pkt_valid` falling in LOAD_DATA (FIFO not full) gives LOAD_PARITY for 1 cycle, then CHECK_PARITY_ERROR for 1 cycle.
- **Minimum packet turnaround**: 4 cycles from header to `detect_add` re-asserting.
- **`fifo_full` and `!pkt_valid` together in LOAD_DATA**: FIFO_FULL_STATE wins. Parity is then taken through LOAD_AFTER_FULL via `low_pkt_valid`.
- **`reset` mid-packet**: DECODE_ADDRESS on the next edge; the packet is abandoned.

## Structure
- Shared package `router_pkg` holds:
  - the state enum (3-bit binary encoding);
  - `INVALID_ADDR`;
  - the port count, fixed at 3.
- No sub-module. Build the three input flags into vectors internally and index them with `addr_q` (or `data_in` in DECODE_ADDRESS).

## Test plan
- **Reset**: hold `reset` = 1 for 2 cycles → `detect_add` = 1, every other output 0, `busy` = 0.
- **Clean packet**: `fifo_empty_1` = 1; header `data_in` = 2'b01 with `pkt_valid`, 3 payload bytes, then `pkt_valid` = 0.
  - Required state sequence: LOAD_FIRST_DATA, LOAD_DATA ×3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
  - `rst_int_reg` pulses for 1 cycle.
- **Invalid address**: header 2'b11 → stays in DECODE_ADDRESS for 5 cycles, `busy` = 0.
- **Busy destination**: `fifo_empty_2` = 0 at header 2'b10 → WAIT_TILL_EMPTY with `busy` = 1. Raising `fifo_empty_2` → LOAD_FIRST_DATA next cycle.
- **Full stall**: `fifo_full` = 1 during LOAD_DATA → FIFO_FULL_STATE for 3 cycles, `write_enb_reg` = 0.
  - Release with `low_pkt_valid` = 1, `parity_done` = 0 → LOAD_AFTER_FULL, then LOAD_PARITY.
- **Soft reset**: in LOAD_DATA for port 0:
  - `soft_reset_1` = 1 → no effect.
  - `soft_reset_0` = 1 → DECODE_ADDRESS next cycle.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the 1x3 router controller
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

endpackage

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet sequencing controller for the 1x3 router
module router_fsm #(
    parameter logic [1:0] INVALID_ADDR = router_pkg::INVALID_ADDR
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    import router_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    // Address 3 is padded with a constant 0 so a 2-bit index never runs off the vector.
    logic [NUM_PORTS:0] empty_vec;
    logic [NUM_PORTS:0] soft_vec;

    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    // Next-state logic: soft reset of the selected port overrides every normal transition.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q != DECODE_ADDRESS && soft_vec[addr_q]) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != INVALID_ADDR) begin
                        addr_d = data_in;
                        // Destination choice uses the live header bits, not the stale address.
                        state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // State, address and registered Moore outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= DECODE_ADDRESS;
            addr_q        <= 2'b00;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            detect_add    <= (state_d == DECODE_ADDRESS);
            lfd_state     <= (state_d == LOAD_FIRST_DATA);
            ld_state      <= (state_d == LOAD_DATA);
            laf_state     <= (state_d == LOAD_AFTER_FULL);
            full_state    <= (state_d == FIFO_FULL_STATE);
            rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
            write_enb_reg <= (state_d == LOAD_FIRST_DATA) || (state_d == LOAD_DATA) ||
                             (state_d == LOAD_PARITY)     || (state_d == LOAD_AFTER_FULL);
            busy          <= !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed scoreboard bench for router_fsm
module tb_router_fsm;

    typedef enum int { S_DA, S_WTE, S_LFD, S_LD, S_FFS, S_LAF, S_LP, S_CPE } exp_state_e;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    router_fsm dut (
        .clock        (clock),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .write_enb_reg(write_enb_reg),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Output vector order: detect_add lfd ld laf full rst_int write_enb busy
    function automatic logic [7:0] expect_outputs(exp_state_e s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_WTE:   return 8'b0000_0001;
            S_LFD:   return 8'b0100_0011;
            S_LD:    return 8'b0010_0010;
            S_FFS:   return 8'b0000_1001;
            S_LAF:   return 8'b0001_0011;
            S_LP:    return 8'b0000_0011;
            S_CPE:   return 8'b0000_0101;
            default: return 8'bxxxx_xxxx;
        endcase
    endfunction

    task automatic step(input exp_state_e s, input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        string      t;
        exp_q.push_back(expect_outputs(s));
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", t, obs, exp);
        end
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        // Reset held two cycles
        reset = 1'b1;
        step(S_DA, "reset_0");
        step(S_DA, "reset_1");
        reset = 1'b0;

        // Clean packet to port 1
        fifo_empty_1 = 1'b1; pkt_valid = 1'b1; data_in = 2'b01;
        step(S_LFD, "clean_hdr");
        data_in = 2'b00;
        step(S_LD, "clean_pl1");
        step(S_LD, "clean_pl2");
        step(S_LD, "clean_pl3");
        pkt_valid = 1'b0;
        step(S_LP, "clean_parity");
        step(S_CPE, "clean_check");
        step(S_DA, "clean_done");

        // Invalid address held for five cycles
        pkt_valid = 1'b1; data_in = 2'b11;
        for (int i = 0; i < 5; i++) step(S_DA, "invalid_addr");

        // Busy destination then full stall released into parity via low_pkt_valid
        fifo_empty_2 = 1'b0; data_in = 2'b10;
        step(S_WTE, "wait_empty_0");
        data_in = 2'b00;
        step(S_WTE, "wait_empty_1");
        fifo_empty_2 = 1'b1;
        step(S_LFD, "wait_released");
        step(S_LD, "busy_dest_ld");
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step(S_FFS, "full_0");
        step(S_FFS, "full_1");
        step(S_FFS, "full_2");
        fifo_full = 1'b0; low_pkt_valid = 1'b1; parity_done = 1'b0;
        step(S_LAF, "laf_enter");
        step(S_LP, "laf_to_parity");
        // Parity check with FIFO full goes back to the stall state
        fifo_full = 1'b1;
        step(S_CPE, "check_again");
        step(S_FFS, "check_full");
        fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b1;
        step(S_LAF, "laf_enter2");
        step(S_DA, "laf_parity_done");
        parity_done = 1'b0;

        // LOAD_AFTER_FULL with neither flag returns to LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'b01;
        step(S_LFD, "p1_hdr");
        step(S_LD, "p1_ld");
        fifo_full = 1'b1;
        step(S_FFS, "p1_full");
        fifo_full = 1'b0;
        step(S_LAF, "p1_laf");
        step(S_LD, "p1_laf_to_ld");

        // Soft reset: other port ignored, selected port aborts
        soft_reset_0 = 1'b1;
        step(S_LD, "p1_soft0_ignored");
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        step(S_DA, "p1_soft1");
        soft_reset_1 = 1'b0;

        // Soft reset for port 0 in LOAD_DATA
        data_in = 2'b00; fifo_empty_0 = 1'b1;
        step(S_LFD, "p0_hdr");
        step(S_LD, "p0_ld");
        soft_reset_1 = 1'b1;
        step(S_LD, "p0_soft1_ignored");
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step(S_DA, "p0_soft0");
        soft_reset_0 = 1'b0;

        // Soft reset outranks a pending transition in WAIT_TILL_EMPTY
        fifo_empty_2 = 1'b0; data_in = 2'b10;
        step(S_WTE, "p2_wait");
        fifo_empty_2 = 1'b1; soft_reset_2 = 1'b1;
        step(S_DA, "p2_soft_over_empty");
        soft_reset_2 = 1'b0;

        // fifo_full and !pkt_valid together: full wins
        data_in = 2'b01;
        step(S_LFD, "tie_hdr");
        step(S_LD, "tie_ld");
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step(S_FFS, "tie_full_wins");
        fifo_full = 1'b0;

        // Reset mid-packet
        reset = 1'b1;
        step(S_DA, "reset_mid");
        reset = 1'b0;
        step(S_DA, "after_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
